fir_mac_pipeline: RTL

FIR_MAC_PIPELINE -- requirements
Module: fir_mac_pipeline

---
 rtl/fir_mac_pipeline.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/fir_mac_pipeline.sv
// fir_mac_pipeline: fixed-point dot product of TAPS signed sample/coefficient pairs.
// LANES multipliers retire one group per cycle, so a result is ready N = TAPS/LANES
// cycles after acceptance. The result is rounded half-up, shifted right by SHIFT and
// saturated to OUT_WIDTH. The block then holds the result until out_ready is seen.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   taps_flat, coeffs_flat    packed signed operands; element i is [WIDTH*(i+1)-1 -: WIDTH]
//   in_valid / in_ready       operand handshake; in_ready is high only in IDLE
//   out_data, out_sat         rounded, saturated result and its clip flag; 0 unless out_valid
//   out_valid / out_ready     result handshake
module fir_mac_pipeline #(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 8,
  parameter int LANES     = 2,
  parameter int SHIFT     = 15,
  parameter int OUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAPS*WIDTH-1:0] taps_flat,
  input  logic [TAPS*WIDTH-1:0] coeffs_flat,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int ACC_W = 2*WIDTH + $clog2(TAPS);
  localparam int N     = TAPS / LANES;
  localparam int GW    = (N > 1) ? $clog2(N) : 1;
  localparam int BSH   = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [GW-1:0] G_LAST = GW'(N - 1);

  // Rounding and saturation use one extra bit so that adding the half-LSB bias
  // cannot overflow the accumulator width.
  localparam logic signed [ACC_W:0] BIAS =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << BSH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W+2-OUT_WIDTH){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state_q, state_d;
  logic [TAPS*WIDTH-1:0] taps_q, taps_d;
  logic [TAPS*WIDTH-1:0] coeffs_q, coeffs_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [GW-1:0]         g_q, g_d;
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_sat_q, out_sat_d;

  logic [WIDTH-1:0]         lane_a, lane_b;
  logic signed [2*WIDTH-1:0] prod;
  logic [ACC_W-1:0]         grp_sum;
  logic [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W:0]    rnd_ext;
  logic signed [ACC_W:0]    rnd_r;
  logic [OUT_WIDTH-1:0]     rnd_data;
  logic                     rnd_sat;

  // Operands are muxed by group index before the multipliers, so only LANES
  // multipliers exist regardless of TAPS.
  always_comb begin
    lane_a  = '0;
    lane_b  = '0;
    prod    = '0;
    grp_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_a = '0;
      lane_b = '0;
      for (int gi = 0; gi < N; gi++) begin
        if (g_q == GW'(gi)) begin
          lane_a = taps_q[(gi*LANES+j)*WIDTH +: WIDTH];
          lane_b = coeffs_q[(gi*LANES+j)*WIDTH +: WIDTH];
        end
      end
      prod    = $signed(lane_a) * $signed(lane_b);
      grp_sum = grp_sum + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end
    acc_sum = acc_q + grp_sum;
  end

  // Round half toward +infinity, then clip to the signed output range.
  always_comb begin
    rnd_ext  = $signed({acc_sum[ACC_W-1], acc_sum}) + BIAS;
    rnd_r    = rnd_ext >>> SHIFT;
    rnd_data = rnd_r[OUT_WIDTH-1:0];
    rnd_sat  = 1'b0;
    if (rnd_r > SAT_MAX) begin
      rnd_data = SAT_MAX[OUT_WIDTH-1:0];
      rnd_sat  = 1'b1;
    end else if (rnd_r < SAT_MIN) begin
      rnd_data = SAT_MIN[OUT_WIDTH-1:0];
      rnd_sat  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    taps_d     = taps_q;
    coeffs_d   = coeffs_q;
    acc_d      = acc_q;
    g_d        = g_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          taps_d   = taps_flat;
          coeffs_d = coeffs_flat;
          acc_d    = '0;
          g_d      = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_sum;
        g_d   = g_q + GW'(1);
        if (g_q == G_LAST) begin
          // Result is registered on the final beat so it is stable for all of HOLD.
          out_data_d = rnd_data;
          out_sat_d  = rnd_sat;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_data_d = '0;
          out_sat_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      taps_q     <= '0;
      coeffs_q   <= '0;
      acc_q      <= '0;
      g_q        <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      taps_q     <= taps_d;
      coeffs_q   <= coeffs_d;
      acc_q      <= acc_d;
      g_q        <= g_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // in_ready is held low during reset so nothing is accepted before release.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
